// File: rtl/dram_req_arbiter_pkg.sv
// Shared types and constants for the DRAM request arbiter.
//   state_t          : arbiter FSM states
//   BURST_INCR       : AXI INCR burst encoding
//   RESP_OKAY        : AXI OKAY response encoding
//   size_from_bytes  : AXI size field (log2 of beat bytes)
package dram_req_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP,
    RESPOND
  } state_t;

  localparam int unsigned AXI_LEN_BITS   = 8;
  localparam int unsigned AXI_SIZE_BITS  = 3;
  localparam int unsigned AXI_BURST_BITS = 2;
  localparam int unsigned AXI_RESP_BITS  = 2;
  localparam int unsigned AXI_CACHE_BITS = 4;
  localparam int unsigned AXI_PROT_BITS  = 3;
  localparam int unsigned AXI_QOS_BITS   = 4;

  localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

  // Largest power of two not exceeding nbytes, as an AXI size code.
  function automatic logic [AXI_SIZE_BITS-1:0] size_from_bytes(input int unsigned nbytes);
    logic [AXI_SIZE_BITS-1:0] s;
    s = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if ((32'd1 << i) <= nbytes) s = AXI_SIZE_BITS'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/dram_req_arbiter_if.sv
// Bundle of requester-side and AXI4-side signals of the DRAM arbiter.
//   master modport : the arbiter (drives req_ready, rsp_*, AXI AW/W/AR, b_ready, r_ready)
//   slave modport  : requesters plus DRAM model (the reverse directions)
interface dram_req_arbiter_if
  import dram_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned ID_BITS   = 5,
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned STRB_BITS = DATA_BITS / 8
);

  // requester side
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0]           req_write;
  logic [N_REQ*ADDR_BITS-1:0] req_addr;
  logic [N_REQ*DATA_BITS-1:0] req_wdata;
  logic [N_REQ*STRB_BITS-1:0] req_strb;
  logic [N_REQ-1:0]           rsp_valid;
  logic [N_REQ-1:0]           rsp_ready;
  logic [DATA_BITS-1:0]       rsp_rdata;
  logic                       rsp_err;

  // AXI write address
  logic                       axi_aw_valid;
  logic                       axi_aw_ready;
  logic [ADDR_BITS-1:0]       axi_aw_addr;
  logic [AXI_LEN_BITS-1:0]    axi_aw_len;
  logic [AXI_SIZE_BITS-1:0]   axi_aw_size;
  logic [AXI_BURST_BITS-1:0]  axi_aw_burst;
  logic [ID_BITS-1:0]         axi_aw_id;
  logic                       axi_aw_lock;
  logic [AXI_CACHE_BITS-1:0]  axi_aw_cache;
  logic [AXI_PROT_BITS-1:0]   axi_aw_prot;
  logic [AXI_QOS_BITS-1:0]    axi_aw_qos;

  // AXI write data
  logic                       axi_w_valid;
  logic                       axi_w_ready;
  logic [DATA_BITS-1:0]       axi_w_data;
  logic [STRB_BITS-1:0]       axi_w_strb;
  logic                       axi_w_last;

  // AXI write response
  logic                       axi_b_valid;
  logic                       axi_b_ready;
  logic [ID_BITS-1:0]         axi_b_id;
  logic [AXI_RESP_BITS-1:0]   axi_b_resp;

  // AXI read address
  logic                       axi_ar_valid;
  logic                       axi_ar_ready;
  logic [ADDR_BITS-1:0]       axi_ar_addr;
  logic [AXI_LEN_BITS-1:0]    axi_ar_len;
  logic [AXI_SIZE_BITS-1:0]   axi_ar_size;
  logic [AXI_BURST_BITS-1:0]  axi_ar_burst;
  logic [ID_BITS-1:0]         axi_ar_id;
  logic                       axi_ar_lock;
  logic [AXI_CACHE_BITS-1:0]  axi_ar_cache;
  logic [AXI_PROT_BITS-1:0]   axi_ar_prot;
  logic [AXI_QOS_BITS-1:0]    axi_ar_qos;

  // AXI read data
  logic                       axi_r_valid;
  logic                       axi_r_ready;
  logic [DATA_BITS-1:0]       axi_r_data;
  logic [ID_BITS-1:0]         axi_r_id;
  logic [AXI_RESP_BITS-1:0]   axi_r_resp;
  logic                       axi_r_last;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output axi_aw_valid, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst, axi_aw_id,
           axi_aw_lock, axi_aw_cache, axi_aw_prot, axi_aw_qos,
    input  axi_aw_ready,
    output axi_w_valid, axi_w_data, axi_w_strb, axi_w_last,
    input  axi_w_ready,
    input  axi_b_valid, axi_b_id, axi_b_resp,
    output axi_b_ready,
    output axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id,
           axi_ar_lock, axi_ar_cache, axi_ar_prot, axi_ar_qos,
    input  axi_ar_ready,
    input  axi_r_valid, axi_r_data, axi_r_id, axi_r_resp, axi_r_last,
    output axi_r_ready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  axi_aw_valid, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst, axi_aw_id,
           axi_aw_lock, axi_aw_cache, axi_aw_prot, axi_aw_qos,
    output axi_aw_ready,
    input  axi_w_valid, axi_w_data, axi_w_strb, axi_w_last,
    output axi_w_ready,
    output axi_b_valid, axi_b_id, axi_b_resp,
    input  axi_b_ready,
    input  axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id,
           axi_ar_lock, axi_ar_cache, axi_ar_prot, axi_ar_qos,
    output axi_ar_ready,
    output axi_r_valid, axi_r_data, axi_r_id, axi_r_resp, axi_r_last,
    input  axi_r_ready
  );

endinterface

// File: rtl/dram_req_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
//   req           : request vector
//   ptr           : highest-priority index this cycle
//   grant_c       : one-hot grant (combinational)
//   grant_idx_c   : binary index of the grant (combinational)
//   grant_valid_c : any request present (combinational)
module rr_arbiter #(
  parameter  int unsigned N_REQ    = 2,
  localparam int unsigned PTR_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [N_REQ-1:0]    grant_c,
  output logic [PTR_BITS-1:0] grant_idx_c,
  output logic                grant_valid_c
);

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned          idx;
    logic [PTR_BITS-1:0]  pos;
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    idx           = 0;
    pos           = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      pos = PTR_BITS'(idx);
      if (!grant_valid_c && req[pos]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = pos;
        grant_c[pos]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_req_arbiter.sv
// Arbitrates N_REQ requesters onto one AXI4 master, one single-beat
// transaction outstanding at a time, and routes the response back.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : requester handshakes/payloads and AXI4 master channels
module dram_req_arbiter
  import dram_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned ID_BITS   = 5,
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned STRB_BITS = DATA_BITS / 8
) (
  input logic                 clock,
  input logic                 reset,
  dram_req_arbiter_if.master  bus
);

  localparam int unsigned PTR_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AXI_SIZE_BITS-1:0] AXI_SIZE = size_from_bytes(STRB_BITS);

  state_t                state, state_nxt;
  logic [PTR_BITS-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_BITS-1:0]   g_idx, g_idx_nxt;
  logic                  lat_write, lat_write_nxt;
  logic [ADDR_BITS-1:0]  lat_addr, lat_addr_nxt;
  logic [DATA_BITS-1:0]  lat_wdata, lat_wdata_nxt;
  logic [STRB_BITS-1:0]  lat_strb, lat_strb_nxt;
  logic                  aw_done, aw_done_nxt;
  logic                  w_done, w_done_nxt;
  logic [DATA_BITS-1:0]  rsp_rdata, rsp_rdata_nxt;
  logic                  rsp_err, rsp_err_nxt;

  logic [N_REQ-1:0]      grant;
  logic [PTR_BITS-1:0]   grant_idx;
  logic                  grant_valid;
  logic                  aw_now, w_now;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req           (bus.req_valid),
    .ptr           (rr_ptr),
    .grant_c       (grant),
    .grant_idx_c   (grant_idx),
    .grant_valid_c (grant_valid)
  );

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      g_idx     <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      g_idx     <= g_idx_nxt;
      lat_write <= lat_write_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_strb  <= lat_strb_nxt;
      aw_done   <= aw_done_nxt;
      w_done    <= w_done_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    g_idx_nxt     = g_idx;
    lat_write_nxt = lat_write;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    lat_strb_nxt  = lat_strb;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    aw_now        = aw_done || bus.axi_aw_ready;
    w_now         = w_done || bus.axi_w_ready;

    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          g_idx_nxt     = grant_idx;
          lat_write_nxt = bus.req_write[grant_idx];
          lat_addr_nxt  = bus.req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
          lat_wdata_nxt = bus.req_wdata[grant_idx*DATA_BITS +: DATA_BITS];
          lat_strb_nxt  = bus.req_strb[grant_idx*STRB_BITS +: STRB_BITS];
          rr_ptr_nxt    = (grant_idx == PTR_BITS'(N_REQ - 1)) ? '0 : grant_idx + PTR_BITS'(1);
          state_nxt     = bus.req_write[grant_idx] ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (bus.axi_ar_ready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (bus.axi_r_valid) begin
          rsp_rdata_nxt = bus.axi_r_data;
          rsp_err_nxt   = (bus.axi_r_resp != RESP_OKAY) || (bus.axi_r_id != ID_BITS'(g_idx)) ||
                          !bus.axi_r_last;
          state_nxt     = RESPOND;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; both flags are needed to move on.
        if (aw_now && w_now) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = WR_RESP;
        end else begin
          aw_done_nxt = aw_now;
          w_done_nxt  = w_now;
        end
      end
      WR_RESP: begin
        if (bus.axi_b_valid) begin
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = (bus.axi_b_resp != RESP_OKAY) || (bus.axi_b_id != ID_BITS'(g_idx));
          state_nxt     = RESPOND;
        end
      end
      RESPOND: begin
        if (bus.rsp_ready[g_idx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requester-side outputs; req_ready is the only combinational path from inputs.
  always_comb begin
    bus.req_ready = (state == IDLE && !reset) ? grant : '0;
    bus.rsp_valid = (state == RESPOND) ? (N_REQ'(1) << g_idx) : '0;
    bus.rsp_rdata = rsp_rdata;
    bus.rsp_err   = rsp_err;
  end

  // AXI outputs decoded from registered state; attributes fixed for single beats.
  always_comb begin
    bus.axi_ar_valid = (state == RD_ADDR);
    bus.axi_ar_addr  = lat_addr;
    bus.axi_ar_len   = '0;
    bus.axi_ar_size  = AXI_SIZE;
    bus.axi_ar_burst = BURST_INCR;
    bus.axi_ar_id    = ID_BITS'(g_idx);
    bus.axi_ar_lock  = 1'b0;
    bus.axi_ar_cache = '0;
    bus.axi_ar_prot  = '0;
    bus.axi_ar_qos   = '0;
    bus.axi_r_ready  = (state == RD_DATA);

    bus.axi_aw_valid = (state == WR_ADDR_DATA) && !aw_done;
    bus.axi_aw_addr  = lat_addr;
    bus.axi_aw_len   = '0;
    bus.axi_aw_size  = AXI_SIZE;
    bus.axi_aw_burst = BURST_INCR;
    bus.axi_aw_id    = ID_BITS'(g_idx);
    bus.axi_aw_lock  = 1'b0;
    bus.axi_aw_cache = '0;
    bus.axi_aw_prot  = '0;
    bus.axi_aw_qos   = '0;

    bus.axi_w_valid  = (state == WR_ADDR_DATA) && !w_done;
    bus.axi_w_data   = lat_wdata;
    bus.axi_w_strb   = lat_strb;
    bus.axi_w_last   = 1'b1;

    bus.axi_b_ready  = (state == WR_RESP);
  end

  // lat_write is kept for visibility of the accepted request type.
  logic unused_ok;
  assign unused_ok = lat_write;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter with a small single-beat AXI DRAM model.
module tb_dram_req_arbiter;
  import dram_req_arbiter_pkg::*;

  localparam int unsigned ADDR_BITS = 32;
  localparam int unsigned DATA_BITS = 64;
  localparam int unsigned ID_BITS   = 5;
  localparam int unsigned N_REQ     = 2;
  localparam int unsigned STRB_BITS = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dram_req_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS),
                        .N_REQ(N_REQ), .STRB_BITS(STRB_BITS)) bus ();

  dram_req_arbiter #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS),
                     .N_REQ(N_REQ), .STRB_BITS(STRB_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // DRAM model state and captured request fields
  logic [63:0] mem [int unsigned];
  int          aw_stall = 0;
  logic [1:0]  r_resp_force = 2'b00;
  bit          hold_r = 1'b0;
  logic [31:0] ar_addr_c, aw_addr_c;
  logic [4:0]  ar_id_c, aw_id_c;
  logic [7:0]  ar_len_c, aw_len_c;
  logic [2:0]  ar_size_c, aw_size_c;
  logic [1:0]  ar_burst_c, aw_burst_c;
  logic [11:0] ar_attr_c, aw_attr_c;
  logic [63:0] w_data_c;
  logic [7:0]  w_strb_c;
  logic        w_last_c;

  // DRAM model: decisions at negedge, handshakes complete on the next posedge.
  initial begin : dram_model
    bit ar_sched, r_hs_sched, aw_got, w_got, wr_sched, b_hs_sched;
    logic [63:0] word;
    ar_sched = 0; r_hs_sched = 0; aw_got = 0; w_got = 0; wr_sched = 0; b_hs_sched = 0;
    bus.axi_aw_ready = 0; bus.axi_w_ready = 0;
    bus.axi_b_valid = 0; bus.axi_b_id = '0; bus.axi_b_resp = '0;
    bus.axi_ar_ready = 0;
    bus.axi_r_valid = 0; bus.axi_r_data = '0; bus.axi_r_id = '0; bus.axi_r_resp = '0; bus.axi_r_last = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ar_sched = 0; r_hs_sched = 0; aw_got = 0; w_got = 0; wr_sched = 0; b_hs_sched = 0;
        bus.axi_aw_ready = 0; bus.axi_w_ready = 0; bus.axi_b_valid = 0;
        bus.axi_ar_ready = 0; bus.axi_r_valid = 0;
      end else begin
        // read data channel
        if (r_hs_sched) begin bus.axi_r_valid = 0; r_hs_sched = 0; end
        if (ar_sched) begin
          ar_sched = 0;
          if (!hold_r) begin
            bus.axi_r_valid = 1;
            bus.axi_r_data  = mem.exists(ar_addr_c >> 3) ? mem[ar_addr_c >> 3] : 64'h0;
            bus.axi_r_id    = ar_id_c;
            bus.axi_r_resp  = r_resp_force;
            bus.axi_r_last  = 1;
          end
        end
        if (bus.axi_r_valid && bus.axi_r_ready) r_hs_sched = 1;
        // read address channel
        bus.axi_ar_ready = bus.axi_ar_valid;
        if (bus.axi_ar_valid) begin
          ar_sched   = 1;
          ar_addr_c  = bus.axi_ar_addr;
          ar_id_c    = bus.axi_ar_id;
          ar_len_c   = bus.axi_ar_len;
          ar_size_c  = bus.axi_ar_size;
          ar_burst_c = bus.axi_ar_burst;
          ar_attr_c  = {bus.axi_ar_lock, bus.axi_ar_cache, bus.axi_ar_prot, bus.axi_ar_qos};
        end
        // write response channel
        if (b_hs_sched) begin bus.axi_b_valid = 0; b_hs_sched = 0; end
        if (wr_sched) begin
          wr_sched = 0;
          word = mem.exists(aw_addr_c >> 3) ? mem[aw_addr_c >> 3] : 64'h0;
          for (int b = 0; b < 8; b++) if (w_strb_c[b]) word[8*b +: 8] = w_data_c[8*b +: 8];
          mem[aw_addr_c >> 3] = word;
          bus.axi_b_valid = 1;
          bus.axi_b_id    = aw_id_c;
          bus.axi_b_resp  = 2'b00;
        end
        if (bus.axi_b_valid && bus.axi_b_ready) b_hs_sched = 1;
        // write address channel, optionally stalled
        if (bus.axi_aw_valid && !aw_got) begin
          if (aw_stall > 0) begin
            bus.axi_aw_ready = 0;
            aw_stall--;
          end else begin
            bus.axi_aw_ready = 1;
            aw_got     = 1;
            aw_addr_c  = bus.axi_aw_addr;
            aw_id_c    = bus.axi_aw_id;
            aw_len_c   = bus.axi_aw_len;
            aw_size_c  = bus.axi_aw_size;
            aw_burst_c = bus.axi_aw_burst;
            aw_attr_c  = {bus.axi_aw_lock, bus.axi_aw_cache, bus.axi_aw_prot, bus.axi_aw_qos};
          end
        end else begin
          bus.axi_aw_ready = 0;
        end
        // write data channel, always accepted at once
        if (bus.axi_w_valid && !w_got) begin
          bus.axi_w_ready = 1;
          w_got    = 1;
          w_data_c = bus.axi_w_data;
          w_strb_c = bus.axi_w_strb;
          w_last_c = bus.axi_w_last;
        end else begin
          bus.axi_w_ready = 0;
        end
        if (aw_got && w_got) begin wr_sched = 1; aw_got = 0; w_got = 0; end
      end
    end
  end

  // Present a request from requester r and wait until it is accepted.
  task automatic send_req(input string tag, input int r, input bit wr, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [7:0] st);
    bit ok;
    ok = 0;
    @(negedge clock);
    bus.req_write[r] = wr;
    bus.req_addr[r*32 +: 32]  = addr;
    bus.req_wdata[r*64 +: 64] = wd;
    bus.req_strb[r*8 +: 8]    = st;
    bus.req_valid[r] = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (bus.req_ready[r]) ok = 1;
      @(negedge clock);
    end
    bus.req_valid[r] = 1'b0;
    check_eq({tag, "_accept"}, 64'(ok), 64'd1);
  endtask

  // Wait for rsp_valid[r]; returns at negedge+1 with the payload.
  task automatic wait_rsp(input string tag, input int r, output logic [63:0] d, output logic e);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (bus.rsp_valid[r]) ok = 1;
      else @(negedge clock);
    end
    check_eq({tag, "_rsp_seen"}, 64'(ok), 64'd1);
    d = bus.rsp_rdata;
    e = bus.rsp_err;
  endtask

  task automatic ack_rsp(input int r);
    bus.rsp_ready[r] = 1'b1;
    @(negedge clock);
    bus.rsp_ready[r] = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] d, d0;
    logic        e;
    bit          ok;
    int          ng;
    logic [63:0] g;

    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0; bus.rsp_ready = '0;
    mem[32'h100 >> 3] = 64'hDEADBEEF_CAFEF00D;
    mem[32'h40 >> 3]  = 64'hAABBCCDD_EEFF0011;

    // reset state
    #12;
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_valids", 64'({bus.axi_ar_valid, bus.axi_aw_valid, bus.axi_w_valid}), 64'd0);
    check_eq("rst_readys", 64'({bus.axi_r_ready, bus.axi_b_ready}), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // read by requester 0
    send_req("rd0", 0, 1'b0, 32'h100, 64'h0, 8'h00);
    wait_rsp("rd0", 0, d, e);
    check_eq("rd0_rsp_valid_vec", 64'(bus.rsp_valid), 64'b01);
    check_eq("rd0_rdata", d, 64'hDEADBEEF_CAFEF00D);
    check_eq("rd0_err", 64'(e), 64'd0);
    check_eq("rd0_ar_id", 64'(ar_id_c), 64'd0);
    check_eq("rd0_ar_len", 64'(ar_len_c), 64'd0);
    check_eq("rd0_ar_size", 64'(ar_size_c), 64'd3);
    check_eq("rd0_ar_burst", 64'(ar_burst_c), 64'd1);
    check_eq("rd0_ar_attr", 64'(ar_attr_c), 64'd0);
    ack_rsp(0);

    // write by requester 1 with AW held off for 3 cycles
    aw_stall = 3;
    send_req("wr1", 1, 1'b1, 32'h40, 64'h11223344_55667788, 8'h0F);
    #1;
    check_eq("wr1_aw_valid_c0", 64'(bus.axi_aw_valid), 64'd1);
    check_eq("wr1_w_valid_c0", 64'(bus.axi_w_valid), 64'd1);
    @(negedge clock); #1;
    check_eq("wr1_w_valid_c1", 64'(bus.axi_w_valid), 64'd0);
    check_eq("wr1_aw_valid_c1", 64'(bus.axi_aw_valid), 64'd1);
    @(negedge clock);
    @(negedge clock); #1;
    check_eq("wr1_aw_valid_c3", 64'(bus.axi_aw_valid), 64'd1);
    check_eq("wr1_b_ready_c3", 64'(bus.axi_b_ready), 64'd0);
    @(negedge clock); #1;
    check_eq("wr1_b_ready_c4", 64'(bus.axi_b_ready), 64'd1);
    check_eq("wr1_aw_valid_c4", 64'(bus.axi_aw_valid), 64'd0);
    wait_rsp("wr1", 1, d, e);
    check_eq("wr1_rsp_valid_vec", 64'(bus.rsp_valid), 64'b10);
    check_eq("wr1_err", 64'(e), 64'd0);
    check_eq("wr1_rdata", d, 64'd0);
    check_eq("wr1_aw_id", 64'(aw_id_c), 64'd1);
    check_eq("wr1_aw_addr", 64'(aw_addr_c), 64'h40);
    check_eq("wr1_aw_fields", 64'({aw_len_c, aw_size_c, aw_burst_c, aw_attr_c}),
             64'({8'd0, 3'd3, 2'b01, 12'd0}));
    check_eq("wr1_w_strb", 64'(w_strb_c), 64'h0F);
    check_eq("wr1_w_last", 64'(w_last_c), 64'd1);
    ack_rsp(1);

    // readback by requester 1
    send_req("rd1", 1, 1'b0, 32'h40, 64'h0, 8'h00);
    wait_rsp("rd1", 1, d, e);
    check_eq("rd1_rdata", d, 64'hAABBCCDD_55667788);
    check_eq("rd1_err", 64'(e), 64'd0);
    check_eq("rd1_ar_id", 64'(ar_id_c), 64'd1);
    ack_rsp(1);

    // contention: both requesters valid for 6 grants
    @(negedge clock);
    bus.req_write = '0;
    bus.req_addr  = {32'h100, 32'h100};
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    ng = 0;
    for (int i = 0; i < 300 && ng < 6; i++) begin
      #1;
      if (|bus.req_ready) begin
        g = bus.req_ready[1] ? 64'd1 : 64'd0;
        check_eq($sformatf("cont_grant%0d", ng), g, 64'(ng % 2));
        check_eq($sformatf("cont_onehot%0d", ng), 64'($countones(bus.req_ready)), 64'd1);
        ng++;
      end
      @(negedge clock);
    end
    bus.req_valid = '0;
    check_eq("cont_grant_count", 64'(ng), 64'd6);
    repeat (20) @(negedge clock);
    bus.rsp_ready = '0;

    // read error from the DRAM, response held without rsp_ready
    r_resp_force = 2'b10;
    send_req("err0", 0, 1'b0, 32'h100, 64'h0, 8'h00);
    wait_rsp("err0", 0, d0, e);
    check_eq("err0_err", 64'(e), 64'd1);
    check_eq("err0_rdata", d0, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      check_eq($sformatf("err0_hold_valid%0d", i), 64'(bus.rsp_valid), 64'b01);
      check_eq($sformatf("err0_hold_data%0d", i), bus.rsp_rdata, d0);
      check_eq($sformatf("err0_hold_err%0d", i), 64'(bus.rsp_err), 64'd1);
    end
    ack_rsp(0);
    r_resp_force = 2'b00;

    // reset while waiting for read data; requester 0 was just granted
    hold_r = 1'b1;
    send_req("rst0", 0, 1'b0, 32'h200, 64'h0, 8'h00);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (bus.axi_r_ready) ok = 1;
      else @(negedge clock);
    end
    check_eq("rst0_in_rd_data", 64'(ok), 64'd1);
    bus.req_addr  = {32'h100, 32'h100};
    bus.req_valid = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst0_r_ready", 64'(bus.axi_r_ready), 64'd0);
    check_eq("rst0_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst0_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst0_valids", 64'({bus.axi_ar_valid, bus.axi_aw_valid, bus.axi_w_valid, bus.axi_b_ready}),
             64'd0);
    @(negedge clock);
    hold_r = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst0_first_grant", 64'(bus.req_ready), 64'b01);
    @(negedge clock);
    bus.req_valid = '0;
    wait_rsp("rst0_after", 0, d, e);
    check_eq("rst0_after_rdata", d, 64'hDEADBEEF_CAFEF00D);
    check_eq("rst0_after_err", 64'(e), 64'd0);
    ack_rsp(0);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
